// File: rtl/nlut_pkg.sv
// Shared 4-bit nonlinear lookup tables and the inverse engine state encoding.
package nlut_pkg;

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/inv_sbox4.sv
// Combinational inverse 4-bit S-box lookup.
module inv_sbox4 (
  input  logic [3:0] nib,
  output logic [3:0] sub_c
);

  always_comb begin
    sub_c = 4'h0;
    case (nib)
      4'h0: sub_c = 4'h5;
      4'h1: sub_c = 4'hE;
      4'h2: sub_c = 4'hF;
      4'h3: sub_c = 4'h8;
      4'h4: sub_c = 4'hC;
      4'h5: sub_c = 4'h1;
      4'h6: sub_c = 4'h2;
      4'h7: sub_c = 4'hD;
      4'h8: sub_c = 4'hB;
      4'h9: sub_c = 4'h4;
      4'hA: sub_c = 4'h6;
      4'hB: sub_c = 4'h3;
      4'hC: sub_c = 4'h0;
      4'hD: sub_c = 4'h7;
      4'hE: sub_c = 4'h9;
      4'hF: sub_c = 4'hA;
      default: sub_c = 4'h0;
    endcase
  end

endmodule

// File: rtl/inverse_sbox_engine.sv
// Nibble-serial inverse substitution engine with valid/ready on both sides.
// One shared S-box instance walks the word LSB nibble first.
module inverse_sbox_engine
  import nlut_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t                   state_q, state_d;
  logic [NIBBLES-1:0][3:0]  work_q, work_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [W-1:0]             out_data_d;
  logic                     in_ready_d, out_valid_d, busy_d;
  logic [3:0]               nib_sel, nib_sub;

  inv_sbox4 u_inv_sbox4 (
    .nib   (nib_sel),
    .sub_c (nib_sub)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    out_data_d = out_data;
    nib_sel    = work_q[cnt_q];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d[cnt_q] = nib_sub;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          out_data_d = work_d;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs; reset overrides any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      out_data  <= out_data_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_inverse_sbox_engine.sv
// Self-checking bench for inverse_sbox_engine with NIBBLES=4.
module tb_inverse_sbox_engine;
  import nlut_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  inverse_sbox_engine #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inv_word(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = SBOX_INV[w[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [15:0] fwd_word(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = SBOX_FWD[w[4*i +: 4]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait for the accept edge, then count cycles until out_valid.
  task automatic send(input logic [15:0] d, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  initial begin
    logic [15:0] dir_in  [3];
    logic [15:0] dir_exp [3];
    logic [15:0] w, held, last_res;
    logic [15:0] b2b_in  [4];
    int lat, cyc, idx, got, last_acc;
    logic acc, seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 16'h0000);

    // Directed words with known answers.
    dir_in  = '{16'h0000, 16'h0123, 16'hFEDC};
    dir_exp = '{16'h5555, 16'h5EF8, 16'hA970};
    for (int k = 0; k < 3; k++) begin
      send(dir_in[k], lat);
      check("dir_latency", lat, 4);
      check("dir_data", out_data, dir_exp[k]);
      check("dir_busy_done", busy, 1);
      tick();
      check("dir_back_idle", in_ready, 1);
      check("dir_hold_data", out_data, dir_exp[k]);
    end

    // Every nibble value replicated across the word, plus round trip.
    for (int i = 0; i < 16; i++) begin
      w = {4{4'(i)}};
      send(w, lat);
      check("exh_latency", lat, 4);
      check("exh_data", out_data, {4{SBOX_INV[i]}});
      check("exh_roundtrip", fwd_word(out_data), w);
      tick();
    end

    // Random words against the model.
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      send(w, lat);
      check("rnd_latency", lat, 4);
      check("rnd_data", out_data, inv_word(w));
      tick();
    end

    // Backpressure: hold in DONE, in_valid pulses must be ignored.
    out_ready = 1'b0;
    w = 16'hC3A5;
    send(w, lat);
    check("bp_latency", lat, 4);
    held = out_data;
    check("bp_data", held, inv_word(w));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'($urandom);
      tick();
      check("bp_stable", out_data, held);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);
    tick();
    check("bp_no_accept", busy, 0);

    // Reset while cnt==2.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_in_ready", in_ready, 1);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_out_data", out_data, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_result", seen, 0);

    // Back-to-back words with in_valid held high.
    b2b_in = '{16'h1357, 16'h9BDF, 16'h0F1E, 16'h8421};
    cyc = 0; idx = 0; got = 0; last_acc = -1;
    in_valid = 1'b1;
    in_data  = b2b_in[0];
    while (got < 4 && cyc < 80) begin
      acc = in_ready && in_valid;
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) check("b2b_gap", 32'(cyc - last_acc), 6);
        last_acc = cyc;
        idx++;
        if (idx < 4) in_data = b2b_in[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b_data", out_data, inv_word(b2b_in[got]));
        got++;
      end
    end
    check("b2b_count", got, 4);
    last_res = inv_word(b2b_in[3]);
    tick();
    check("b2b_final_hold", out_data, last_res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
